// File: rtl/charlieplex_scan.sv
// charlieplex_scan: double-buffered PWM charlieplex LED scanner (optional blanking: CHARLIEPLEX_GHOST_BLANK_EN)
module charlieplex_scan #(
  parameter int N = 7,
  parameter int BITS = 4,
  parameter int PRESCALE = 256,
  localparam int L = N * (N - 1),
  localparam int AW = $clog2(L)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [BITS-1:0] wr_data,
  input  logic            swap,
  output logic            swap_pending,
  output logic            frame_start,
  output logic [N-1:0]    oe,
  output logic [N-1:0]    o
);
  localparam int S = 1 << BITS;
  localparam int QW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int RW = $clog2(N);
  localparam int PW = BITS + 1;
`ifdef CHARLIEPLEX_GHOST_BLANK_EN
  localparam int PLAST = S;
`else
  localparam int PLAST = S - 1;
`endif
  logic [BITS-1:0] fb [2][L];
  logic            fsel;
  logic [QW-1:0]   q;
  logic [PW-1:0]   ps;
  logic [AW-1:0]   k;
  logic [RW-1:0]   r, c, lo;
  logic            q_end, p_end, k_end, c_end, boundary, lit;
  logic [BITS-1:0] level;
  logic [N-1:0]    hmask, lmask;
  always_comb begin
    q_end = q == QW'(PRESCALE - 1);
    p_end = ps == PW'(PLAST);
    k_end = k == AW'(L - 1);
    c_end = c == RW'(N - 2);
    boundary = q_end && p_end && k_end;
    level = fb[fsel][k];
`ifdef CHARLIEPLEX_GHOST_BLANK_EN
    // step 0 of each slot is the blanking step; PWM steps are shifted by one
    lit = ps != '0 && ps <= {1'b0, level};
`else
    lit = ps < {1'b0, level};
`endif
    lo = c < r ? c : c + RW'(1);
    hmask = N'(1) << r;
    lmask = N'(1) << lo;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oe <= '0;
      o <= '0;
      frame_start <= 1'b0;
      swap_pending <= 1'b0;
      fsel <= 1'b0;
      q <= '0;
      ps <= '0;
      k <= '0;
      r <= '0;
      c <= '0;
      for (int i = 0; i < L; i++) begin
        fb[0][i] <= '0;
        fb[1][i] <= '0;
      end
    end else begin
      oe <= lit ? (hmask | lmask) : '0;
      o <= lit ? hmask : '0;
      frame_start <= q == '0 && ps == '0 && k == '0;
      q <= q_end ? '0 : q + 1'b1;
      if (q_end) ps <= p_end ? '0 : ps + 1'b1;
      // row/column tracked alongside k so no divider is needed for pin mapping
      if (q_end && p_end) begin
        k <= k_end ? '0 : k + 1'b1;
        c <= c_end ? '0 : c + 1'b1;
        r <= k_end ? '0 : (c_end ? r + 1'b1 : r);
      end
      if (wr_en && {1'b0, wr_addr} < (AW + 1)'(L)) fb[!fsel][wr_addr] <= wr_data;
      if (boundary) begin
        if (swap_pending || swap) fsel <= !fsel;
        swap_pending <= 1'b0;
      end else if (swap) swap_pending <= 1'b1;
    end
  end
endmodule

// File: doc/charlieplex_scan.md
Name: charlieplex_scan

Overview:
- Generalised charlieplexed LED matrix driver for N tristate pins, which gives N*(N-1) LEDs.
- Holds a double-buffered per-LED brightness framebuffer and scans one LED at a time with PWM dimming.
- Buffers swap only on frame boundaries, so updates never tear.
- Sits between the SPI/Wishbone register logic and the board-level SB_IO tristate pads; its oe/o outputs drive OUTPUT_ENABLE/D_OUT_0 directly.

Parameters:
- N, 7, number of charlieplex pins (>=3); LED count L = N*(N-1).
- BITS, 4, brightness bits per LED; PWM steps S = 2^BITS.
- PRESCALE, 256, clocks per PWM step (>=1).
- Derived localparam AW = clog2(L), framebuffer address width.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- wr_en  input  1  framebuffer write strobe
- wr_addr  input  AW  LED index 0..L-1
- wr_data  input  BITS  brightness level
- swap  input  1  request to exchange front/back buffers at the next frame boundary
- swap_pending  output  1  swap requested, not yet applied
- frame_start  output  1  one-cycle pulse, aligned with the first output cycle of LED 0
- oe  output  N  pin output enables
- o  output  N  pin output values

Behaviour:
- Reset (asynchronous, immediate):
  - oe=0, o=0, swap_pending=0, frame_start=0.
  - Both buffers cleared to 0; front = buffer 0.
  - LED index k=0, PWM step p=0, prescaler q=0.
- LED mapping for index k:
  - r = k/(N-1), c = k%(N-1).
  - High pin h = r; low pin lo = (c<r) ? c : c+1.
- Scan counters:
  - q counts 0..PRESCALE-1.
  - On q wrap, p increments 0..S-1.
  - On p wrap, k increments 0..L-1.
  - The k wrap from L-1 to 0 is the frame boundary.
  - Slot dwell is S*PRESCALE clocks; frame length is L*S*PRESCALE clocks.
- Output drive:
  - LED k is lit during step p iff p < front[k]. Level 0 is always dark; level S-1 is lit for S-1 of S steps.
  - Lit: oe has bits h and lo set, all others 0; o has only bit h set.
  - Dark: oe=0, o=0.
- Output timing:
  - oe, o and frame_start are registered and reflect the counters with 1-cycle latency.
  - frame_start is high for exactly one cycle per frame.
- Writes:
  - wr_en writes wr_data to the back buffer at wr_addr in the same clock.
  - wr_addr >= L: write ignored, no state change.
  - Front-buffer contents are never modified by writes.
- Swap:
  - swap high sets swap_pending on the next clock, unless that clock is a frame boundary.
  - On the boundary clock, if (swap_pending | swap), front and back exchange, swap_pending clears, and the new front takes effect from LED 0.
  - swap while already pending: no extra effect.
  - wr_en and swap in the same cycle: the write lands in the pre-swap back buffer, which becomes front at the boundary.
  - A write on the boundary clock itself goes to the buffer that is back before the exchange.
  - After an exchange the back buffer holds the old front image; there is no copy.
- Reset mid-frame: outputs go dark asynchronously; scan restarts at k=0 after rst_n release; the first frame_start follows on the first active clock.

Optional Feature:
- Macro CHARLIEPLEX_GHOST_BLANK_EN.
- Defined:
  - Each LED slot is prefixed with PRESCALE blanking clocks with oe=0, o=0, to discharge pin capacitance and suppress ghosting.
  - Slot dwell becomes (S+1)*PRESCALE clocks; PWM steps follow the blank.
  - frame_start aligns with the first blank cycle of LED 0.
- Not defined: no blanking; dwell is S*PRESCALE clocks.

Test Plan (N=3, BITS=2, PRESCALE=1 unless stated; L=6, dwell 4, frame 24):
- Reset: pulse rst_n low mid-frame -> oe=000/o=000 with no clock edge; after release, frame_start pulses every 24 clocks; all slots dark, since buffers are zero.
- Write addr 3 = 3, pulse swap -> swap_pending=1 until the boundary, then 0. In the next frame, slot 3 (h=1, lo=2) shows oe=110/o=010 for 3 clocks, then 000 for 1 clock. Other slots stay dark.
- Write addr 5 = 1 plus swap -> slot 5 (h=2, lo=1) shows oe=110/o=100 for 1 clock per frame. The previous image is gone, because the back buffer held the old front.
- Write addr 6 = 3 (out of range) then swap -> displayed image unchanged versus the swap-only control.
- Assert swap on exactly the boundary clock -> exchange happens at that boundary; swap_pending never rises. A second swap during pending -> a single exchange only.
- With CHARLIEPLEX_GHOST_BLANK_EN: dwell 5, frame 30. The first clock of every slot has oe=000. Slot 3 at level 3 is lit on clocks 2..4 of its slot.
